// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start(0), port, length, payload, [parity], stop(1).
// Define SER_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_frame_tx #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  tx_valid,
    input  logic [PORT_W-1:0]     tx_port,
    input  logic [LEN_W-1:0]      tx_len,
    input  logic [2**LEN_W-2:0]   tx_data,
    output logic                  tx_ready,
    output logic                  Ser_Out,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = 2**LEN_W - 1;
    localparam int HW = PORT_W + LEN_W;
    localparam int CW = (PORT_W > LEN_W) ? PORT_W : LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA,
`ifdef SER_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hdr_q, hdr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ser_q, ser_d;
    state_e          tail_s;
    logic            tail_b;

`ifdef SER_TX_PARITY_EN
    logic par_q, par_d;
    logic [DW-1:0] pay_mask;

    assign pay_mask = ~({DW{1'b1}} << tx_len);
    assign tail_s   = S_PARITY;
    assign tail_b   = par_q;
`else
    assign tail_s   = S_STOP;
    assign tail_b   = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b1;
`ifdef SER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
`ifdef SER_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Port and length share one MSB-first shift register; payload is
    // left-aligned at acceptance so bit L-1 leaves first.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        done    = 1'b0;
`ifdef SER_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                if (tx_valid) begin
                    state_d = S_WAIT;
                    hdr_d   = {tx_port, tx_len};
                    len_d   = tx_len;
                    data_d  = tx_data << (DW - int'(tx_len));
`ifdef SER_TX_PARITY_EN
                    par_d   = ^{tx_port, tx_len, tx_data & pay_mask};
`endif
                end
            end
            S_WAIT: begin
                if (clk_en) begin
                    state_d = S_START;
                    ser_d   = 1'b0;
                end
            end
            S_START: begin
                if (clk_en) begin
                    state_d = S_PORT;
                    ser_d   = hdr_q[HW-1];
                    hdr_d   = hdr_q << 1;
                    cnt_d   = CW'(PORT_W - 1);
                end
            end
            S_PORT: begin
                if (clk_en) begin
                    ser_d = hdr_q[HW-1];
                    hdr_d = hdr_q << 1;
                    if (cnt_q == '0) begin
                        state_d = S_LEN;
                        cnt_d   = CW'(LEN_W - 1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_LEN: begin
                if (clk_en) begin
                    if (cnt_q != '0) begin
                        ser_d = hdr_q[HW-1];
                        hdr_d = hdr_q << 1;
                        cnt_d = cnt_q - CW'(1);
                    end else if (len_q == '0) begin
                        state_d = tail_s;
                        ser_d   = tail_b;
                    end else begin
                        state_d = S_DATA;
                        ser_d   = data_q[DW-1];
                        data_d  = data_q << 1;
                        cnt_d   = CW'(len_q) - CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (clk_en) begin
                    if (cnt_q == '0) begin
                        state_d = tail_s;
                        ser_d   = tail_b;
                    end else begin
                        ser_d  = data_q[DW-1];
                        data_d = data_q << 1;
                        cnt_d  = cnt_q - CW'(1);
                    end
                end
            end
`ifdef SER_TX_PARITY_EN
            S_PARITY: begin
                if (clk_en) begin
                    state_d = S_STOP;
                    ser_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (clk_en) begin
                    state_d = S_IDLE;
                    ser_d   = 1'b1;
                    done    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign Ser_Out  = ser_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized bench for serial_frame_tx against a bit-list frame model.
// Build with SER_TX_PARITY_EN defined to cover the parity variant.
module tb_serial_frame_tx;

    localparam int PW = 2;
    localparam int LW = 4;
    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic          tx_valid;
    logic [PW-1:0] tx_port;
    logic [LW-1:0] tx_len;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          Ser_Out;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int en_mode  = 0;
    int ph       = 0;

    serial_frame_tx #(
        .PORT_W (PW),
        .LEN_W  (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .tx_valid (tx_valid),
        .tx_port  (tx_port),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .Ser_Out  (Ser_Out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // 0: always on, 1: every 4th cycle, 2: random
    initial begin
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (en_mode)
                0:       clk_en = 1'b1;
                1:       clk_en = (ph % 4 == 0);
                default: clk_en = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic req(input logic [PW-1:0] p, input logic [LW-1:0] l,
                       input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_port  = p;
        tx_len   = l;
        tx_data  = d;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", tx_ready, 1);
        check("idle_line", Ser_Out, 1);
        check("idle_done", done, 0);
    endtask

    // Follows one frame from its acceptance cycle to the done cycle.
    task automatic track(input logic [PW-1:0] p, input logic [LW-1:0] l,
                         input logic [DW-1:0] d, input bit nv,
                         input logic [PW-1:0] np, input logic [LW-1:0] nl,
                         input logic [DW-1:0] nd);
        bit bits[$];
        int b;
        int cyc;
        bit en;
        logic exp_line;
`ifdef SER_TX_PARITY_EN
        int ones;
`endif
        bits.push_back(1'b0);
        for (int i = PW - 1; i >= 0; i--) bits.push_back(p[i]);
        for (int i = LW - 1; i >= 0; i--) bits.push_back(l[i]);
        for (int i = int'(l) - 1; i >= 0; i--) bits.push_back(d[i]);
`ifdef SER_TX_PARITY_EN
        ones = 0;
        foreach (bits[i]) ones += int'(bits[i]);
        bits.push_back(ones[0]);
`endif
        bits.push_back(1'b1);

        @(negedge clk);
        check("acc_ready", tx_ready, 1);
        check("acc_line", Ser_Out, 1);
        @(posedge clk);
        #1;
        tx_valid = nv;
        if (nv) begin
            tx_port = np;
            tx_len  = nl;
            tx_data = nd;
        end else begin
            tx_port = PW'($urandom);
            tx_len  = LW'($urandom);
            tx_data = DW'($urandom);
        end

        b   = -1;
        cyc = 0;
        while (b < bits.size() && cyc < 2000) begin
            @(negedge clk);
            en = clk_en;
            if (b < 0) exp_line = 1'b1;
            else       exp_line = bits[b];
            check("busy", busy, 1);
            check("ready", tx_ready, 0);
            check("line", Ser_Out, exp_line);
            check("done", done, (b == bits.size() - 1) && en);
            if (en) b++;
            cyc++;
        end
        if (cyc >= 2000) check("frame_timeout", 0, 1);
    endtask

    logic [PW-1:0] rp, rp2;
    logic [LW-1:0] rl, rl2;
    logic [DW-1:0] rd, rd2;
    bit            b2b;

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_port  = '0;
        tx_len   = '0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_line", Ser_Out, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #2 rst = 1'b0;

        repeat (100) idle_check();

        en_mode = 0;
        req(2'b10, 4'd3, 15'h0005);
        track(2'b10, 4'd3, 15'h0005, 0, '0, '0, '0);
        idle_check();

        req(2'b10, 4'd3, 15'h7FF5);
        track(2'b10, 4'd3, 15'h7FF5, 0, '0, '0, '0);
        idle_check();

        req(2'b01, 4'd0, 15'h7FFF);
        track(2'b01, 4'd0, 15'h7FFF, 0, '0, '0, '0);
        idle_check();

        en_mode = 1;
        req(2'b11, 4'd15, 15'h5555);
        track(2'b11, 4'd15, 15'h5555, 0, '0, '0, '0);
        idle_check();

        en_mode = 0;
        req(2'b01, 4'd5, 15'h0013);
        track(2'b01, 4'd5, 15'h0013, 1, 2'b10, 4'd2, 15'h0002);
        track(2'b10, 4'd2, 15'h0002, 0, '0, '0, '0);
        idle_check();

        req(2'b11, 4'd15, 15'h0000);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_line", Ser_Out, 0);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_line", Ser_Out, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_done", done, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_done", done, 0);
        end
        #2 rst = 1'b0;
        idle_check();
        req(2'b10, 4'd7, 15'h004B);
        track(2'b10, 4'd7, 15'h004B, 0, '0, '0, '0);
        idle_check();

        for (int k = 0; k < 30; k++) begin
            en_mode = int'($urandom_range(0, 2));
            rp  = PW'($urandom);
            rl  = LW'($urandom);
            rd  = DW'($urandom);
            rp2 = PW'($urandom);
            rl2 = LW'($urandom);
            rd2 = DW'($urandom);
            b2b = ($urandom_range(0, 2) == 0);
            req(rp, rl, rd);
            track(rp, rl, rd, b2b, rp2, rl2, rd2);
            if (b2b) track(rp2, rl2, rd2, 0, '0, '0, '0);
            idle_check();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter for the multi-channel serial link: it turns a parallel request (destination port, payload length, payload bits) into the single-wire frame consumed by the receiving controller. Frame format: start bit (0), port field, length field, payload bits, stop bit (1). The line idles high. The block sits on the sending side, ahead of the link. Bit timing is set by the shared `clk_en` bit-rate strobe.

## Interface
- `PORT_W`, default 2: port field width in bits.
- `LEN_W`, default 4: length field width in bits. Maximum payload is `2**LEN_W-1` bits (15).
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `clk_en`  input  1  bit-rate strobe; one bit period = one `clk` cycle with `clk_en`=1.
- `tx_valid`  input  1  request present.
- `tx_port`  input  PORT_W  destination port.
- `tx_len`  input  LEN_W  payload length L in bits, 0..15.
- `tx_data`  input  2**LEN_W-1  payload; bits [L-1:0] are sent, upper bits are ignored.
- `tx_ready`  output  1  block can accept a request; high only in IDLE.
- `Ser_Out`  output  1  serial line.
- `busy`  output  1  high from acceptance until the stop bit ends.
- `done`  output  1  one-`clk` pulse at the end of the stop bit.

## Operation
- States: IDLE, WAIT, START, PORT, LEN, DATA, (PARITY), STOP.
- IDLE: `tx_ready`=1, `Ser_Out`=1.
  - Acceptance happens when `tx_valid` & `tx_ready` on any `clk` edge, independent of `clk_en`.
  - On acceptance, latch port, len and data, then go to WAIT.
- WAIT: on the next `clk_en` tick, go to START and drive `Ser_Out`=0.
- Every later state transition and every `Ser_Out` change occurs only on `clk_en` ticks. One state bit is held per tick.
- START lasts 1 tick. Then PORT.
- PORT sends `tx_port` MSB first for PORT_W ticks, using a down-counter. Then LEN.
- LEN sends `tx_len` MSB first for LEN_W ticks.
  - If L=0, go straight to PARITY or STOP.
  - Otherwise go to DATA.
- DATA sends `tx_data[L-1]` down to `tx_data[0]`, L ticks. Then PARITY or STOP.
- STOP drives `Ser_Out`=1 for 1 tick. At the tick that ends STOP:
  - `done`=1 for that one `clk` cycle.
  - State returns to IDLE, so `tx_ready` is 1 on the next cycle.
- Frame length in bit periods: 8+L, plus 1 if parity is compiled in.
- `tx_valid` while busy is ignored; the request is not queued.
- `tx_*` may change after acceptance without affecting the frame in flight.
- Reset (async, at any point including mid-frame):
  - `Ser_Out`=1, `busy`=0, `done`=0, `tx_ready`=1, state=IDLE.
  - The partial frame is abandoned.

## Timing
- `Ser_Out` is driven from a flop, so it has no combinational path from any input.
- Acceptance to the start bit on the line: until the next `clk_en` tick, minimum 1 `clk`.
  - If `clk_en`=1 in the acceptance cycle, that tick does not count; WAIT needs a later tick.
- Back-to-back frames: the earliest next acceptance is the `clk` cycle after `done`. The next start bit is therefore always preceded by at least 1 full high stop bit.
- `clk_en` permanently high gives 1 bit per `clk`. The frame then occupies 8+L consecutive cycles after WAIT.

## Configuration
- `SER_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA (or LEN when L=0) and STOP.
  - It sends 1 bit equal to the XOR of all port, length and sent payload bits, giving even parity.
  - Frame length is 9+L.
- Undefined: no PARITY state and no parity logic; frame length is 8+L.

## Test plan
- Reset then idle: `rst` pulse -> `Ser_Out`=1, `tx_ready`=1, `busy`=0, `done`=0, no line activity for 100 cycles.
- Basic frame: `clk_en`=1, port=2'b10, len=3, data=3'b101 -> `Ser_Out` over ticks is 0,1,0,0,0,1,1,1,0,1,1. `done` pulses on the 11th tick. With `SER_TX_PARITY_EN` the sequence is 0,1,0,0,0,1,1,1,0,1,1,1 (parity bit 1 before stop).
- Zero length: port=2'b01, len=0, data=15'h7FFF -> 0,0,1,0,0,0,0,1. No payload bits are sent and the upper data bits are ignored.
- Bit-rate strobe: `clk_en` every 4th cycle, len=15, data=15'h5555 -> each bit held exactly 4 `clk` cycles, 23 bit periods total, `busy` high throughout.
- Busy and back-to-back: `tx_valid` held high with a second request queued -> the second request is not accepted until the cycle after `done`. The line shows exactly one stop-bit 1 between frames, and fields changed mid-frame do not alter the first frame.
- Mid-frame reset: assert `rst` during the DATA bits -> `Ser_Out` goes to 1 asynchronously, no `done` pulse. The next request transmits a complete, correct frame.
